mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle MIPS32 control FSM that drives the ALU from the control side.
- Decodes the IR and sequences IF/ID/EX/MEM/WB with a memory ready-handshake.
- Emits ALUFun/Sign codes, operand selects and datapath strobes to a shared datapath: one ALU, one unified memory.

Parameters:
- RESET_STATE, 3'd0, encoding loaded into state on reset (IF).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- instr  input  32  current IR contents, stable from ID onward
- mem_ready  input  1  memory completes the requested access this cycle
- mem_req  output  1  memory access request; held until mem_ready
- mem_write  output  1  request is a store
- ir_write  output  1  load IR from memory data
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU S[0]==1
- pc_source  output  2  0 ALU S, 1 ALUOut, 2 jump target, 3 reg A
- alu_src_a  output  2  0 PC, 1 reg A, 2 shamt instr[10:6], 3 const 16
- alu_src_b  output  2  0 reg B, 1 const 4, 2 ext imm, 3 sext imm<<2
- ext_op  output  1  1 sign-extend imm, 0 zero-extend
- ALUFun  output  6  ALU function code
- Sign  output  1  signed compare/overflow
- reg_write  output  1  register file write strobe
- reg_dst  output  2  0 rt, 1 rd, 2 r31
- mem_to_reg  output  2  0 ALUOut, 1 MDR, 2 PC
- illegal  output  1  one-cycle pulse on unsupported opcode
- state  output  3  current FSM state

Behaviour:
- Reset: state=IF asynchronously. While reset is low, every output except state is 0.
- Outputs are combinational from state and instr. Unlisted strobes are 0.
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- IF(0): mem_req=1, ALU PC+4 (src_a 0, src_b 1, ADD).
  - When mem_ready=0, stay in IF with all strobes held.
  - When mem_ready=1, also assert ir_write=1, pc_write=1, pc_source=0, then go to ID.
- ID(1): ALU PC + (sext imm<<2) into ALUOut (src_a 0, src_b 3, ADD). Next state EX.
- EX(2), decoded by opcode/funct:
  - R-type ALU ops (add/addu/sub/subu/and/or/xor/nor/slt/sltu): src_a 1, src_b 0. Next WB.
  - Shifts sll/srl/sra: src_a 2, src_b 0. Next WB.
  - addi/addiu/slti/sltiu: ext_op 1. andi/ori/xori: ext_op 0. Both: src_b 2. Next WB.
  - lui: src_a 3, src_b 2, ext_op 0, SLL. Next WB.
  - lw/sw: src_a 1, src_b 2, ext_op 1, ADD. Next MEM.
  - beq/bne: src_a 1, src_b 0, EQ/NEQ. blez/bgtz/bltz: same sources, LEZ/GTZ/LTZ.
    - All branches: pc_write_cond=1, pc_source=1. Next IF.
  - j: pc_write, pc_source 2. Next IF.
  - jal: as j, plus reg_write, reg_dst 2, mem_to_reg 2. PC is already +4. Next IF.
  - jr: pc_write, pc_source 3. Next IF.
  - Unsupported opcode/funct: illegal=1 for this cycle, no strobes. Next IF.
- Sign:
  - 1 for add, sub, addi, slt, slti and all branches.
  - 0 for addu, subu, addiu, sltu, sltiu and logic ops.
- MEM(3): mem_req=1, mem_write=1 for sw. Hold while mem_ready=0.
  - On mem_ready, sw goes to IF and lw goes to WB.
- WB(4): reg_write=1.
  - lw: mem_to_reg 1, reg_dst 0.
  - I-type: mem_to_reg 0, reg_dst 0.
  - R-type: mem_to_reg 0, reg_dst 1.
  - Next IF.
- Undefined state codes (5-7) return to IF next cycle with no strobes.
- Reset asserted mid-access: mem_req drops immediately and the access is abandoned.
- A ready pulse arriving with mem_req=0 is ignored.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined, adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every clock after reset.
  - instr_cnt increments on each transition into IF from EX, MEM or WB.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and registers are absent.

Test Plan:
- Reset low, then release with mem_ready=0 -> while reset is low all strobes are 0 and state=0. After release, state=0 and mem_req=1 hold until mem_ready.
- add $3,$1,$2 (0x00221820), mem_ready=1 in IF -> states 0,1,2,4,0.
  - EX: ALUFun=000000, Sign=1, src_a=1, src_b=0.
  - WB: reg_write=1, reg_dst=1.
- lw 0x8C220004 with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req=1 and mem_write=0. Then WB with mem_to_reg=1.
- beq 0x10220003 -> EX: ALUFun=110011, pc_write_cond=1, pc_source=1. Returns to IF; total 3 cycles with immediate ready.
- sll $2,$1,4 (0x00011100) -> EX: ALUFun=100000, src_a=2. Then opcode 0x3F -> illegal pulses 1 cycle in EX, state returns to 0.
- With MC_PERF_CNT_EN: run add, sw, j with ready always 1 -> instr_cnt=3 and cycle_cnt=11 after the third return to IF.

Source files
------------

// File: rtl/mc_control_if.sv
// mc_control_if: control-side bundle between the mc_control FSM and the shared
// single-ALU / unified-memory datapath.
//   master : the control FSM (drives strobes, samples instr and mem_ready)
//   slave  : the datapath / memory side
// Signals: instr (IR contents), mem_ready/mem_req/mem_write (memory handshake),
// ir_write, pc_write, pc_write_cond, pc_source, alu_src_a, alu_src_b, ext_op,
// ALUFun, Sign, reg_write, reg_dst, mem_to_reg, illegal, state.
interface mc_control_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_op;
    logic [5:0]  ALUFun;
    logic        Sign;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        illegal;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ready,
        output mem_req, mem_write, ir_write, pc_write, pc_write_cond, pc_source,
               alu_src_a, alu_src_b, ext_op, ALUFun, Sign, reg_write, reg_dst,
               mem_to_reg, illegal, state
    );

    modport slave (
        output instr, mem_ready,
        input  mem_req, mem_write, ir_write, pc_write, pc_write_cond, pc_source,
               alu_src_a, alu_src_b, ext_op, ALUFun, Sign, reg_write, reg_dst,
               mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS32 control FSM (IF/ID/EX/MEM/WB) driving a shared
// datapath with one ALU and one unified memory using a ready handshake.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   bus    - mc_control_if.master: instr/mem_ready in, all control strobes out
// Optional (macro MC_PERF_CNT_EN):
//   cycle_cnt - clocks since reset
//   instr_cnt - instructions retired (entries into IF from EX, MEM or WB)
// All strobes are combinational from state and instr, and forced to 0 while
// reset is low.
module mc_control #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]  cycle_cnt,
    output logic [31:0]  instr_cnt
`endif
);
    localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_AND = 6'b011000,
                           F_OR  = 6'b011110, F_XOR = 6'b010110, F_NOR = 6'b010001,
                           F_SLL = 6'b100000, F_SRL = 6'b100001, F_SRA = 6'b100011,
                           F_EQ  = 6'b110011, F_NEQ = 6'b110001, F_LT  = 6'b110101,
                           F_LEZ = 6'b111101, F_LTZ = 6'b111011, F_GTZ = 6'b111111;

    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_e;

    // Instruction class: selects sources in EX and the path after EX.
    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_SHIFT, C_IMM, C_LUI, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR
    } cls_e;

    state_e      state_q, state_d;
    cls_e        cls;
    logic [5:0]  dec_fun;
    logic        dec_sign, dec_ext;
    logic [5:0]  opcode, funct;
    logic [4:0]  rt;

    logic        mem_req, mem_write, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
    logic        ext_op, sign, reg_write, illegal;
    logic [5:0]  alu_fun;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign rt     = bus.instr[20:16];

    // rs, rd, shamt and the rest of imm are datapath-only fields.
    logic unused_instr;
    assign unused_instr = ^{bus.instr[25:21], bus.instr[15:6]};

    // Instruction decode
    always_comb begin
        cls      = C_ILL;
        dec_fun  = F_ADD;
        dec_sign = 1'b0;
        dec_ext  = 1'b0;
        unique case (opcode)
            6'h00: begin
                unique case (funct)
                    6'h20: begin cls = C_RALU;  dec_sign = 1'b1; end
                    6'h21: begin cls = C_RALU;  end
                    6'h22: begin cls = C_RALU;  dec_fun = F_SUB; dec_sign = 1'b1; end
                    6'h23: begin cls = C_RALU;  dec_fun = F_SUB; end
                    6'h24: begin cls = C_RALU;  dec_fun = F_AND; end
                    6'h25: begin cls = C_RALU;  dec_fun = F_OR;  end
                    6'h26: begin cls = C_RALU;  dec_fun = F_XOR; end
                    6'h27: begin cls = C_RALU;  dec_fun = F_NOR; end
                    6'h2A: begin cls = C_RALU;  dec_fun = F_LT;  dec_sign = 1'b1; end
                    6'h2B: begin cls = C_RALU;  dec_fun = F_LT;  end
                    6'h00: begin cls = C_SHIFT; dec_fun = F_SLL; end
                    6'h02: begin cls = C_SHIFT; dec_fun = F_SRL; end
                    6'h03: begin cls = C_SHIFT; dec_fun = F_SRA; end
                    6'h08: begin cls = C_JR;    end
                    default: ;
                endcase
            end
            // REGIMM: only bltz (rt == 0) is supported
            6'h01: if (rt == 5'd0) begin cls = C_BR; dec_fun = F_LTZ; dec_sign = 1'b1; end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h04: begin cls = C_BR;  dec_fun = F_EQ;  dec_sign = 1'b1; end
            6'h05: begin cls = C_BR;  dec_fun = F_NEQ; dec_sign = 1'b1; end
            6'h06: begin cls = C_BR;  dec_fun = F_LEZ; dec_sign = 1'b1; end
            6'h07: begin cls = C_BR;  dec_fun = F_GTZ; dec_sign = 1'b1; end
            6'h08: begin cls = C_IMM; dec_ext = 1'b1; dec_sign = 1'b1; end
            6'h09: begin cls = C_IMM; dec_ext = 1'b1; end
            6'h0A: begin cls = C_IMM; dec_ext = 1'b1; dec_fun = F_LT; dec_sign = 1'b1; end
            6'h0B: begin cls = C_IMM; dec_ext = 1'b1; dec_fun = F_LT; end
            6'h0C: begin cls = C_IMM; dec_fun = F_AND; end
            6'h0D: begin cls = C_IMM; dec_fun = F_OR;  end
            6'h0E: begin cls = C_IMM; dec_fun = F_XOR; end
            6'h0F: begin cls = C_LUI; dec_fun = F_SLL; end
            6'h23: begin cls = C_LW;  dec_ext = 1'b1; end
            6'h2B: begin cls = C_SW;  dec_ext = 1'b1; end
            default: ;
        endcase
    end

    // Next state and control outputs
    always_comb begin
        state_d       = S_IF;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        ext_op        = 1'b0;
        alu_fun       = F_ADD;
        sign          = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        illegal       = 1'b0;
        if (reset) begin
            unique case (state_q)
                S_IF: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;               // PC + 4
                    state_d   = S_IF;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b = 2'd3;               // speculative branch target
                    state_d   = S_EX;
                end
                S_EX: begin
                    alu_fun = dec_fun;
                    sign    = dec_sign;
                    ext_op  = dec_ext;
                    unique case (cls)
                        C_RALU:  begin alu_src_a = 2'd1; state_d = S_WB; end
                        C_SHIFT: begin alu_src_a = 2'd2; state_d = S_WB; end
                        C_IMM:   begin alu_src_a = 2'd1; alu_src_b = 2'd2; state_d = S_WB; end
                        C_LUI:   begin alu_src_a = 2'd3; alu_src_b = 2'd2; state_d = S_WB; end
                        C_LW, C_SW: begin alu_src_a = 2'd1; alu_src_b = 2'd2; state_d = S_MEM; end
                        C_BR: begin
                            alu_src_a     = 2'd1;
                            pc_write_cond = 1'b1;
                            pc_source     = 2'd1;
                        end
                        C_J:   begin pc_write = 1'b1; pc_source = 2'd2; end
                        // PC already holds the return address (PC+4)
                        C_JAL: begin
                            pc_write   = 1'b1;
                            pc_source  = 2'd2;
                            reg_write  = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                        end
                        C_JR:  begin pc_write = 1'b1; pc_source = 2'd3; end
                        default: begin
                            alu_fun = F_ADD;
                            sign    = 1'b0;
                            ext_op  = 1'b0;
                            illegal = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_write = (cls == C_SW);
                    state_d   = S_MEM;
                    if (bus.mem_ready) state_d = (cls == C_SW) ? S_IF : S_WB;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls == C_LW) ? 2'd1 : 2'd0;
                    reg_dst    = (cls == C_RALU || cls == C_SHIFT) ? 2'd1 : 2'd0;
                end
                default: ;                          // stray codes recover to IF
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= state_e'(RESET_STATE);
        else        state_q <= state_d;
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_source     = pc_source;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.ext_op        = ext_op;
    assign bus.ALUFun        = alu_fun;
    assign bus.Sign          = sign;
    assign bus.reg_write     = reg_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.illegal       = illegal;
    assign bus.state         = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    // An instruction retires when control returns to IF from a later stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (state_d == S_IF &&
                (state_q == S_EX || state_q == S_MEM || state_q == S_WB))
                instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control. A table of supported
// instructions (expected ALU code, sign, sources) drives a per-instruction
// trace generator that predicts every cycle's outputs for chosen ready delays.
module tb_mc_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_control_if bus();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    mc_control dut (.clk(clk), .reset(reset), .bus(bus),
                    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
    mc_control dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mw, irw, pcw, pcwc;
        logic [1:0] pcs, sa, sb;
        logic       ext;
        logic [5:0] fun;
        logic       sg, rw;
        logic [1:0] rd, m2r;
        logic       ill;
    } ov_t;

    typedef enum {K_R, K_SH, K_I, K_LUI, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_ILL} kind_e;

    typedef struct {
        logic [5:0] op, fn;
        kind_e      k;
        logic [5:0] fun;
        logic       sg;
        logic [1:0] sa, sb;
        logic       ext;
    } ent_t;

    ent_t        tbl[$];
    int          nvec = 0, nerr = 0;
    logic [31:0] ncyc = 0, ninstr = 0;
    logic [31:0] ir = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h ir=%h t=%0t", tag, got, exp, ir, $time);
        end
    endtask

    task automatic ent(input logic [5:0] op, input logic [5:0] fn, input kind_e k,
                       input logic [5:0] fun, input logic sg, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ext);
        ent_t e;
        e.op = op; e.fn = fn; e.k = k; e.fun = fun; e.sg = sg;
        e.sa = sa; e.sb = sb; e.ext = ext;
        tbl.push_back(e);
    endtask

    function automatic ov_t obs();
        ov_t o;
        o.st = bus.state; o.mreq = bus.mem_req; o.mw = bus.mem_write;
        o.irw = bus.ir_write; o.pcw = bus.pc_write; o.pcwc = bus.pc_write_cond;
        o.pcs = bus.pc_source; o.sa = bus.alu_src_a; o.sb = bus.alu_src_b;
        o.ext = bus.ext_op; o.fun = bus.ALUFun; o.sg = bus.Sign;
        o.rw = bus.reg_write; o.rd = bus.reg_dst; o.m2r = bus.mem_to_reg;
        o.ill = bus.illegal;
        return o;
    endfunction

    // Look the instruction up in the supported-instruction table.
    task automatic classify(input logic [31:0] ins, output ent_t e);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        e = '{op: op, fn: fn, k: K_ILL, fun: 6'd0, sg: 1'b0, sa: 2'd0, sb: 2'd0, ext: 1'b0};
        foreach (tbl[i])
            if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn) &&
                (op != 6'h01 || ins[20:16] == 5'd0))
                e = tbl[i];
    endtask

    // One cycle: drive at negedge, check 1 time unit later, advance to next negedge.
    task automatic step(input logic [31:0] ins, input logic rdy, input ov_t e, input string tag);
        bus.instr     = ins;
        bus.mem_ready = rdy;
        #1;
        chk(tag, {4'b0, obs()}, {4'b0, e});
`ifdef MC_PERF_CNT_EN
        chk({tag, ".cyc"}, cycle_cnt, ncyc);
        chk({tag, ".icnt"}, instr_cnt, ninstr);
`endif
        @(negedge clk);
        if (reset) ncyc++;
    endtask

    // Full instruction: ifw/memw are the number of not-ready cycles in IF/MEM.
    // stop_mem_wait > 0 abandons the instruction after that many MEM waits.
    task automatic run_instr(input logic [31:0] ins, input int ifw, input int memw,
                             input int stop_mem_wait);
        ent_t e;
        ov_t  v;
        classify(ins, e);
        v = '0; v.mreq = 1'b1; v.sb = 2'd1;
        for (int w = 0; w < ifw; w++) step(ir, 1'b0, v, "IF.wait");
        v.irw = 1'b1; v.pcw = 1'b1;
        step(ir, 1'b1, v, "IF");
        ir = ins;
        v = '0; v.st = 3'd1; v.sb = 2'd3;
        step(ins, 1'($urandom_range(0, 1)), v, "ID");
        v = '0; v.st = 3'd2;
        if (e.k == K_ILL) v.ill = 1'b1;
        else begin
            v.sa = e.sa; v.sb = e.sb; v.ext = e.ext; v.fun = e.fun; v.sg = e.sg;
        end
        case (e.k)
            K_BR:  begin v.pcwc = 1'b1; v.pcs = 2'd1; end
            K_J:   begin v.pcw = 1'b1; v.pcs = 2'd2; end
            K_JAL: begin v.pcw = 1'b1; v.pcs = 2'd2; v.rw = 1'b1; v.rd = 2'd2; v.m2r = 2'd2; end
            K_JR:  begin v.pcw = 1'b1; v.pcs = 2'd3; end
            default: ;
        endcase
        step(ins, 1'($urandom_range(0, 1)), v, "EX");
        if (e.k == K_LW || e.k == K_SW) begin
            v = '0; v.st = 3'd3; v.mreq = 1'b1; v.mw = (e.k == K_SW);
            for (int w = 0; w < memw; w++) begin
                if (stop_mem_wait > 0 && w == stop_mem_wait) return;
                step(ins, 1'b0, v, "MEM.wait");
            end
            step(ins, 1'b1, v, "MEM");
        end
        if (e.k inside {K_R, K_SH, K_I, K_LUI, K_LW}) begin
            v = '0; v.st = 3'd4; v.rw = 1'b1;
            v.rd  = (e.k == K_R || e.k == K_SH) ? 2'd1 : 2'd0;
            v.m2r = (e.k == K_LW) ? 2'd1 : 2'd0;
            step(ins, 1'($urandom_range(0, 1)), v, "WB");
        end
        ninstr++;
    endtask

    task automatic reset_hold(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.instr     = $urandom;
            #1;
            chk(tag, {4'b0, obs()}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        ent_t        e;
        //  op     fn     kind    ALUFun     sg  sa  sb  ext
        ent(6'h00, 6'h20, K_R,   6'b000000, 1, 1, 0, 0);
        ent(6'h00, 6'h21, K_R,   6'b000000, 0, 1, 0, 0);
        ent(6'h00, 6'h22, K_R,   6'b000001, 1, 1, 0, 0);
        ent(6'h00, 6'h23, K_R,   6'b000001, 0, 1, 0, 0);
        ent(6'h00, 6'h24, K_R,   6'b011000, 0, 1, 0, 0);
        ent(6'h00, 6'h25, K_R,   6'b011110, 0, 1, 0, 0);
        ent(6'h00, 6'h26, K_R,   6'b010110, 0, 1, 0, 0);
        ent(6'h00, 6'h27, K_R,   6'b010001, 0, 1, 0, 0);
        ent(6'h00, 6'h2A, K_R,   6'b110101, 1, 1, 0, 0);
        ent(6'h00, 6'h2B, K_R,   6'b110101, 0, 1, 0, 0);
        ent(6'h00, 6'h00, K_SH,  6'b100000, 0, 2, 0, 0);
        ent(6'h00, 6'h02, K_SH,  6'b100001, 0, 2, 0, 0);
        ent(6'h00, 6'h03, K_SH,  6'b100011, 0, 2, 0, 0);
        ent(6'h00, 6'h08, K_JR,  6'b000000, 0, 0, 0, 0);
        ent(6'h01, 6'h00, K_BR,  6'b111011, 1, 1, 0, 0);
        ent(6'h02, 6'h00, K_J,   6'b000000, 0, 0, 0, 0);
        ent(6'h03, 6'h00, K_JAL, 6'b000000, 0, 0, 0, 0);
        ent(6'h04, 6'h00, K_BR,  6'b110011, 1, 1, 0, 0);
        ent(6'h05, 6'h00, K_BR,  6'b110001, 1, 1, 0, 0);
        ent(6'h06, 6'h00, K_BR,  6'b111101, 1, 1, 0, 0);
        ent(6'h07, 6'h00, K_BR,  6'b111111, 1, 1, 0, 0);
        ent(6'h08, 6'h00, K_I,   6'b000000, 1, 1, 2, 1);
        ent(6'h09, 6'h00, K_I,   6'b000000, 0, 1, 2, 1);
        ent(6'h0A, 6'h00, K_I,   6'b110101, 1, 1, 2, 1);
        ent(6'h0B, 6'h00, K_I,   6'b110101, 0, 1, 2, 1);
        ent(6'h0C, 6'h00, K_I,   6'b011000, 0, 1, 2, 0);
        ent(6'h0D, 6'h00, K_I,   6'b011110, 0, 1, 2, 0);
        ent(6'h0E, 6'h00, K_I,   6'b010110, 0, 1, 2, 0);
        ent(6'h0F, 6'h00, K_LUI, 6'b100000, 0, 3, 2, 0);
        ent(6'h23, 6'h00, K_LW,  6'b000000, 0, 1, 2, 1);
        ent(6'h2B, 6'h00, K_SW,  6'b000000, 0, 1, 2, 1);

        bus.instr = 32'h0;
        bus.mem_ready = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        reset_hold(3, "rst.hold");
        reset = 1'b1;
        ncyc = 0; ninstr = 0;

        // Directed: add (IF wait), sw, j, lw (3 MEM waits), beq, sll, illegal
        run_instr(32'h00221820, 2, 0, 0);
        run_instr(32'hAC220008, 0, 0, 0);
        run_instr(32'h08000010, 0, 0, 0);
        run_instr(32'h8C220004, 0, 3, 0);
        run_instr(32'h10220003, 0, 0, 0);
        run_instr(32'h00011100, 0, 0, 0);
        run_instr(32'hFC000000, 0, 0, 0);
        run_instr(32'h04250000, 0, 0, 0);   // REGIMM with rt != 0

        // Reset in the middle of a memory access abandons it.
        run_instr(32'h8C220004, 0, 3, 1);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst.midmem", {4'b0, obs()}, 32'd0);
        @(negedge clk);
        reset_hold(2, "rst.midmem.hold");
        reset = 1'b1;
        ncyc = 0; ninstr = 0;

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 99) < 85) begin
                e = tbl[$urandom_range(0, tbl.size() - 1)];
                ins = $urandom;
                ins[31:26] = e.op;
                if (e.op == 6'h00) ins[5:0] = e.fn;
                if (e.op == 6'h01 && $urandom_range(0, 3) != 0) ins[20:16] = 5'd0;
            end else begin
                ins = $urandom;
            end
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
